addsub_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one fixed-point add/sub core (FixedPointAddSub: i_start/i_sub/i_operandA/i_operandB in, o_busy/o_valid/o_data/o_overflow out) among N_REQ requesters. It accepts one request at a time and issues a single start pulse to the core. It captures the core result and returns it on a tagged response channel, with a watchdog timeout in case the core never answers. It sits between the filter-tap sequencers and the shared arithmetic unit.

---
 rtl/addsub_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/addsub_rr_scheduler.sv | 160 ++++++++++++++++
 tb/tb_addsub_rr_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_sched_pkg.sv
// Shared types and helpers for the add/sub round-robin scheduler.
// Holds the FSM state encoding, the default datapath width and the id width helper.
package addsub_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int DEFAULT_DATA_W = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: searches upward from i_last+1 (mod N)
// and returns the first requesting index as both a one-hot grant and an encoded id.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_last,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_grant_idx,
  output logic            o_any
);

  int   idx;
  logic found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(i_last) + i) % N;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_idx  = idx[ID_W-1:0];
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Shares one fixed-point add/sub core among N_REQ requesters: round-robin accept,
// single start pulse, watchdog-guarded wait for the result, tagged response.
module addsub_rr_scheduler
  import addsub_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ-1:0]          i_req_sub,
  input  logic [N_REQ*DATA_W-1:0]   i_req_a,
  input  logic [N_REQ*DATA_W-1:0]   i_req_b,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [id_w(N_REQ)-1:0]    o_rsp_id,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_rsp_overflow,
  output logic                      o_rsp_timeout,
  output logic                      o_alu_start,
  output logic                      o_alu_sub,
  output logic [DATA_W-1:0]         o_alu_a,
  output logic [DATA_W-1:0]         o_alu_b,
  input  logic                      i_alu_busy,
  input  logic                      i_alu_valid,
  input  logic [DATA_W-1:0]         i_alu_data,
  input  logic                      i_alu_overflow,
  output logic                      o_busy
);

  localparam int          ID_W      = id_w(N_REQ);
  localparam logic [7:0]  TIMEOUT_W = 8'(TIMEOUT);

  // Handshake: a request is taken in the single cycle o_req_ready[k] is high;
  // a response is taken in the cycle where o_rsp_valid and i_rsp_ready are both high.

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                sub_q, sub_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [7:0]          wd_q, wd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ovf_q, ovf_d;
  logic                to_q, to_d;

  logic [N_REQ-1:0]    arb_grant;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;
  logic                alu_drive;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .i_req       (i_req_valid),
    .i_last      (last_q),
    .o_grant     (arb_grant),
    .o_grant_idx (arb_idx),
    .o_any       (arb_any)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    wd_d    = wd_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          id_d    = arb_idx;
          sub_d   = i_req_sub[arb_idx];
          a_d     = i_req_a[int'(arb_idx)*DATA_W +: DATA_W];
          b_d     = i_req_b[int'(arb_idx)*DATA_W +: DATA_W];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!i_alu_busy) begin
          wd_d    = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A real result beats a watchdog expiry landing in the same cycle.
        if (i_alu_valid) begin
          data_d  = i_alu_data;
          ovf_d   = i_alu_overflow;
          to_d    = 1'b0;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + 8'd1;
          if (wd_q + 8'd1 == TIMEOUT_W) begin
            data_d  = '0;
            ovf_d   = 1'b0;
            to_d    = 1'b1;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          last_d  = id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      wd_q    <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      to_q    <= to_d;
    end
  end

  assign alu_drive      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign o_req_ready    = (state_q == ST_IDLE) ? arb_grant : '0;
  assign o_alu_start    = (state_q == ST_ISSUE) && !i_alu_busy;
  assign o_alu_sub      = alu_drive && sub_q;
  assign o_alu_a        = alu_drive ? a_q : '0;
  assign o_alu_b        = alu_drive ? b_q : '0;
  assign o_rsp_valid    = (state_q == ST_RESP);
  assign o_rsp_id       = o_rsp_valid ? id_q : '0;
  assign o_rsp_data     = o_rsp_valid ? data_q : '0;
  assign o_rsp_overflow = o_rsp_valid && ovf_q;
  assign o_rsp_timeout  = o_rsp_valid && to_q;
  assign o_busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler: the bench plays both requesters and core,
// stepping cycle by cycle and checking outputs at the falling edge.
module tb_addsub_rr_scheduler;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 15;
  localparam int ID_W    = 2;

  logic                    i_clk;
  logic                    i_rst;
  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ-1:0]        i_req_sub;
  logic [N_REQ*DATA_W-1:0] i_req_a;
  logic [N_REQ*DATA_W-1:0] i_req_b;
  logic [N_REQ-1:0]        o_req_ready;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [ID_W-1:0]         o_rsp_id;
  logic [DATA_W-1:0]       o_rsp_data;
  logic                    o_rsp_overflow;
  logic                    o_rsp_timeout;
  logic                    o_alu_start;
  logic                    o_alu_sub;
  logic [DATA_W-1:0]       o_alu_a;
  logic [DATA_W-1:0]       o_alu_b;
  logic                    i_alu_busy;
  logic                    i_alu_valid;
  logic [DATA_W-1:0]       i_alu_data;
  logic                    i_alu_overflow;
  logic                    o_busy;

  int checks = 0;
  int errors = 0;

  addsub_rr_scheduler #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_req_valid    (i_req_valid),
    .i_req_sub      (i_req_sub),
    .i_req_a        (i_req_a),
    .i_req_b        (i_req_b),
    .o_req_ready    (o_req_ready),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_id       (o_rsp_id),
    .o_rsp_data     (o_rsp_data),
    .o_rsp_overflow (o_rsp_overflow),
    .o_rsp_timeout  (o_rsp_timeout),
    .o_alu_start    (o_alu_start),
    .o_alu_sub      (o_alu_sub),
    .o_alu_a        (o_alu_a),
    .o_alu_b        (o_alu_b),
    .i_alu_busy     (i_alu_busy),
    .i_alu_valid    (i_alu_valid),
    .i_alu_data     (i_alu_data),
    .i_alu_overflow (i_alu_overflow),
    .o_busy         (o_busy)
  );

  // Clock and run-time bound
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish before 100000");
    $fatal(1, "bench time limit reached");
  end

  // Driver and checker tasks
  task automatic next_cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic sub);
    i_req_valid[k]                = 1'b1;
    i_req_sub[k]                  = sub;
    i_req_a[k*DATA_W +: DATA_W]   = a;
    i_req_b[k*DATA_W +: DATA_W]   = b;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    next_cyc();
    next_cyc();
    i_rst = 1'b0;
  endtask

  int         exp_id [5] = '{0, 1, 2, 3, 0};
  logic [7:0] exp_a  [5] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h20};
  logic [3:0] one_hot;

  initial begin
    i_rst          = 1'b1;
    i_req_valid    = '0;
    i_req_sub      = '0;
    i_req_a        = '0;
    i_req_b        = '0;
    i_rsp_ready    = 1'b0;
    i_alu_busy     = 1'b0;
    i_alu_valid    = 1'b0;
    i_alu_data     = '0;
    i_alu_overflow = 1'b0;

    // Reset state
    do_reset();
    settle();
    chk("rst_busy", o_busy, 0);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_req_ready", o_req_ready, 0);
    chk("rst_alu_start", o_alu_start, 0);
    chk("rst_alu_a", o_alu_a, 0);

    // Single add from req0, core latency 1
    next_cyc();
    set_req(0, 8'h10, 8'h05, 1'b0);
    settle();
    chk("t1_ready", o_req_ready, 4'b0001);
    next_cyc();
    i_req_valid = '0;
    settle();
    chk("t1_start", o_alu_start, 1);
    chk("t1_alu_a", o_alu_a, 8'h10);
    chk("t1_alu_b", o_alu_b, 8'h05);
    chk("t1_alu_sub", o_alu_sub, 0);
    next_cyc();
    i_alu_valid = 1'b1;
    i_alu_data  = 8'h15;
    settle();
    chk("t1_wait_start", o_alu_start, 0);
    chk("t1_wait_a", o_alu_a, 8'h10);
    chk("t1_wait_rsp", o_rsp_valid, 0);
    next_cyc();
    i_alu_valid = 1'b0;
    i_alu_data  = '0;
    i_rsp_ready = 1'b1;
    settle();
    chk("t1_rsp_valid", o_rsp_valid, 1);
    chk("t1_rsp_id", o_rsp_id, 0);
    chk("t1_rsp_data", o_rsp_data, 8'h15);
    chk("t1_rsp_ovf", o_rsp_overflow, 0);
    chk("t1_rsp_to", o_rsp_timeout, 0);
    chk("t1_rsp_alu_a", o_alu_a, 0);
    next_cyc();
    i_rsp_ready = 1'b0;
    settle();
    chk("t1_idle_rsp", o_rsp_valid, 0);
    chk("t1_idle_busy", o_busy, 0);

    // All four requesters continuously valid after reset
    do_reset();
    for (int k = 0; k < N_REQ; k++) set_req(k, 8'h20 + 8'(k), 8'h01, 1'b0);
    for (int op = 0; op < 5; op++) begin
      one_hot = 4'b0001 << exp_id[op];
      settle();
      chk("rr_ready", o_req_ready, one_hot);
      next_cyc();
      settle();
      chk("rr_start", o_alu_start, 1);
      chk("rr_alu_a", o_alu_a, exp_a[op]);
      chk("rr_ready_issue", o_req_ready, 0);
      next_cyc();
      i_alu_valid = 1'b1;
      i_alu_data  = 8'hA0 + 8'(op);
      settle();
      chk("rr_ready_wait", o_req_ready, 0);
      next_cyc();
      i_alu_valid = 1'b0;
      i_rsp_ready = 1'b1;
      settle();
      chk("rr_rsp_id", o_rsp_id, exp_id[op]);
      chk("rr_rsp_data", o_rsp_data, 8'hA0 + 8'(op));
      chk("rr_ready_resp", o_req_ready, 0);
      next_cyc();
      i_rsp_ready = 1'b0;
    end
    i_req_valid = '0;

    // Core busy for 5 cycles in ISSUE; last grant is 0 so req2 wins alone
    set_req(2, 8'h33, 8'h44, 1'b1);
    settle();
    chk("busy_ready", o_req_ready, 4'b0100);
    next_cyc();
    i_req_valid = '0;
    i_alu_busy  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("busy_no_start", o_alu_start, 0);
      chk("busy_alu_sub", o_alu_sub, 1);
      next_cyc();
    end
    i_alu_busy = 1'b0;
    set_req(1, 8'h11, 8'h22, 1'b0);
    settle();
    chk("busy_start", o_alu_start, 1);
    chk("busy_alu_a", o_alu_a, 8'h33);
    chk("busy_alu_b", o_alu_b, 8'h44);
    next_cyc();
    i_alu_valid    = 1'b1;
    i_alu_data     = 8'hEF;
    i_alu_overflow = 1'b1;
    settle();
    chk("busy_one_start", o_alu_start, 0);
    next_cyc();
    i_alu_valid    = 1'b0;
    i_alu_data     = '0;
    i_alu_overflow = 1'b0;

    // Response stalled for 10 cycles with req1 pending
    for (int c = 0; c < 10; c++) begin
      settle();
      chk("stall_valid", o_rsp_valid, 1);
      chk("stall_id", o_rsp_id, 2);
      chk("stall_data", o_rsp_data, 8'hEF);
      chk("stall_ovf", o_rsp_overflow, 1);
      chk("stall_ready", o_req_ready, 0);
      chk("stall_start", o_alu_start, 0);
      next_cyc();
    end
    i_rsp_ready = 1'b1;
    settle();
    chk("hs_no_accept", o_req_ready, 0);
    next_cyc();
    i_rsp_ready = 1'b0;
    settle();
    chk("hs_rsp_drop", o_rsp_valid, 0);
    chk("hs_next_ready", o_req_ready, 4'b0010);

    // Core never answers: watchdog response after 15 WAIT cycles
    next_cyc();
    i_req_valid = '0;
    settle();
    chk("to_start", o_alu_start, 1);
    chk("to_alu_a", o_alu_a, 8'h11);
    next_cyc();
    for (int c = 0; c < TIMEOUT; c++) begin
      settle();
      chk("to_waiting", o_rsp_valid, 0);
      next_cyc();
    end
    i_alu_valid = 1'b1;
    i_alu_data  = 8'h55;
    settle();
    chk("to_rsp_valid", o_rsp_valid, 1);
    chk("to_rsp_timeout", o_rsp_timeout, 1);
    chk("to_rsp_data", o_rsp_data, 0);
    chk("to_rsp_ovf", o_rsp_overflow, 0);
    chk("to_rsp_id", o_rsp_id, 1);
    i_rsp_ready = 1'b1;
    next_cyc();
    i_rsp_ready = 1'b0;
    settle();
    chk("late_valid_busy", o_busy, 0);
    chk("late_valid_rsp", o_rsp_valid, 0);
    next_cyc();
    i_alu_valid = 1'b0;
    i_alu_data  = '0;

    // Reset during WAIT; afterwards req0 beats req3
    set_req(2, 8'h01, 8'h02, 1'b0);
    settle();
    chk("rw_ready", o_req_ready, 4'b0100);
    next_cyc();
    i_req_valid = '0;
    next_cyc();
    settle();
    chk("rw_in_wait", o_busy, 1);
    i_rst = 1'b1;
    next_cyc();
    i_rst = 1'b0;
    settle();
    chk("rw_busy", o_busy, 0);
    chk("rw_alu_a", o_alu_a, 0);
    chk("rw_alu_start", o_alu_start, 0);
    chk("rw_rsp_valid", o_rsp_valid, 0);
    chk("rw_req_ready", o_req_ready, 0);
    next_cyc();
    set_req(0, 8'h0A, 8'h0B, 1'b1);
    set_req(3, 8'h3A, 8'h3B, 1'b0);
    i_alu_valid = 1'b1;
    settle();
    chk("rw_prio_ready", o_req_ready, 4'b0001);
    chk("rw_stale_rsp", o_rsp_valid, 0);
    next_cyc();
    i_req_valid = '0;
    i_alu_valid = 1'b0;
    settle();
    chk("rw_prio_a", o_alu_a, 8'h0A);
    chk("rw_prio_sub", o_alu_sub, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
